// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake on one side, decode/control
// signals on the other. The fetch unit is the master.
interface fetch_unit_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic [31:0]       instr;
   logic [10:0]       opcode;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              pc_src;
   logic [ADDR_W-1:0] branch_offset;
   logic              stall;
   logic [CNT_W-1:0]  retired;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_pc, instr_valid, retired,
      input  imem_ack, imem_rdata, pc_src, branch_offset, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_pc, instr_valid, retired,
      output imem_ack, imem_rdata, pc_src, branch_offset, stall
   );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: req/ack word reads, latched instruction for decode,
// next-PC selection from pc_src and the word branch offset.
//
// state | meaning
// FETCH | imem_req high, waiting for imem_ack at address pc
// EXEC  | instr valid to decode; advance pc and retire when stall is low
module fetch_unit #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] PC_RESET = '0,
   parameter int                CNT_W    = 32
) (
   input logic         clk,
   input logic         rst,
   fetch_unit_if.master bus
);
   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] instr_pc, instr_pc_nxt;
   logic [31:0]       instr, instr_nxt;
   logic [CNT_W-1:0]  retired, retired_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= PC_RESET;
         instr    <= '0;
         instr_pc <= '0;
         retired  <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         instr    <= instr_nxt;
         instr_pc <= instr_pc_nxt;
         retired  <= retired_nxt;
      end
   end

   // pc_src/branch_offset only reach pc_nxt on a non-stalled EXEC edge, so
   // unknown values there while unsampled never land in a register.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr;
      instr_pc_nxt = instr_pc;
      retired_nxt  = retired;
      case (state)
         FETCH: begin
            if (bus.imem_ack) begin
               instr_nxt    = bus.imem_rdata;
               instr_pc_nxt = pc;
               state_nxt    = EXEC;
            end
         end
         EXEC: begin
            if (!bus.stall) begin
               if (bus.pc_src)
                  pc_nxt = instr_pc + (bus.branch_offset << 2);
               else
                  pc_nxt = instr_pc + ADDR_W'(4);
               retired_nxt = retired + CNT_W'(1);
               state_nxt   = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   assign bus.imem_req    = (state == FETCH);
   assign bus.instr_valid = (state == EXEC);
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr;
   assign bus.opcode      = instr[31:21];
   assign bus.instr_pc    = instr_pc;
   assign bus.retired     = retired;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: the driver pushes each expected fetch
// (address, word, retire count) and a negedge monitor compares DUT outputs.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(64), .CNT_W(32)) bus ();

   fetch_unit #(.ADDR_W(64), .PC_RESET(64'd0), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
      logic [31:0] ret;
   } txn_t;

   txn_t        q[$];
   txn_t        cur;
   logic        prev_valid = 1'b0;
   logic [63:0] mpc = 64'd0;
   logic [31:0] mret = 32'd0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: address while requesting, instruction on valid rise, hold during stall.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("req_excl_valid", {63'd0, bus.imem_req}, {63'd0, ~bus.instr_valid});
            if (bus.imem_req && q.size() > 0)
               chk("imem_addr", bus.imem_addr, q[0].pc);
            if (bus.instr_valid && !prev_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_valid", 64'd1, 64'd0);
               end else begin
                  cur = q.pop_front();
                  chk("instr", {32'd0, bus.instr}, {32'd0, cur.ins});
                  chk("opcode", {53'd0, bus.opcode}, {53'd0, cur.ins[31:21]});
                  chk("instr_pc", bus.instr_pc, cur.pc);
                  chk("retired", {32'd0, bus.retired}, {32'd0, cur.ret});
               end
            end else if (bus.instr_valid && prev_valid) begin
               chk("hold_instr", {32'd0, bus.instr}, {32'd0, cur.ins});
               chk("hold_instr_pc", bus.instr_pc, cur.pc);
               chk("hold_retired", {32'd0, bus.retired}, {32'd0, cur.ret});
            end
            prev_valid = bus.instr_valid;
         end else begin
            prev_valid = 1'b0;
         end
      end
   end

   // One instruction: w wait cycles, ack, ns stalled EXEC cycles, then release.
   task automatic run_instr(input logic [31:0] rd, input int w, input int ns,
                            input logic src, input logic [63:0] off);
      txn_t t;
      t.pc  = mpc;
      t.ins = rd;
      t.ret = mret;
      q.push_back(t);
      bus.imem_ack = 1'b0;
      repeat (w) begin
         bus.imem_rdata = $urandom;
         @(negedge clk);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = rd;
      @(negedge clk);
      repeat (ns) begin
         bus.imem_ack      = 1'($urandom);
         bus.imem_rdata    = $urandom;
         bus.stall         = 1'b1;
         bus.pc_src        = 1'($urandom);
         bus.branch_offset = {$urandom, $urandom};
         @(negedge clk);
      end
      bus.imem_ack      = 1'($urandom);
      bus.imem_rdata    = $urandom;
      bus.stall         = 1'b0;
      bus.pc_src        = src;
      bus.branch_offset = off;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      mret = mret + 32'd1;
      if (src)
         mpc = mpc + off * 64'd4;
      else
         mpc = mpc + 64'd4;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req"}, {63'd0, bus.imem_req}, 64'd1);
      chk({tag, "_addr"}, bus.imem_addr, 64'd0);
      chk({tag, "_valid"}, {63'd0, bus.instr_valid}, 64'd0);
      chk({tag, "_retired"}, {32'd0, bus.retired}, 64'd0);
      chk({tag, "_instr"}, {32'd0, bus.instr}, 64'd0);
      chk({tag, "_opcode"}, {53'd0, bus.opcode}, 64'd0);
   endtask

   initial begin
      logic [63:0] off;
      int          s;
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = 32'd0;
      bus.pc_src        = 1'b0;
      bus.branch_offset = 64'd0;
      bus.stall         = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Directed walk: first-cycle ack, sequential, delayed ack, branches, stall, wrap.
      run_instr(32'h8B02_0020, 0, 0, 1'b0, 64'd0);
      run_instr($urandom, 0, 0, 1'b0, 64'd0);
      run_instr($urandom, 3, 0, 1'b0, 64'd0);
      run_instr($urandom, 0, 0, 1'b1, 64'd13);
      run_instr($urandom, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      run_instr($urandom, 0, 0, 1'b1, 64'd5);
      run_instr($urandom, 0, 3, 1'b0, 64'd0);
      off = (64'hFFFF_FFFF_FFFF_FFFC - mpc) >> 2;
      run_instr($urandom, 0, 0, 1'b1, off);
      run_instr($urandom, 1, 1, 1'b0, 64'd0);
      chk("wrap_model_pc", mpc, 64'd0);

      repeat (300) begin
         s = int'($urandom_range(0, 40)) - 20;
         if ($urandom_range(0, 7) == 0)
            off = {$urandom, $urandom};
         else
            off = 64'(longint'(s));
         run_instr($urandom, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   1'($urandom), off);
      end

      // Asynchronous reset in the middle of EXEC.
      q.push_back('{pc: mpc, ins: 32'hD65F_03C0, ret: mret});
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hD65F_03C0;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.stall    = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      q.delete();
      mpc  = 64'd0;
      mret = 32'd0;
      bus.stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_instr($urandom, 0, 0, 1'b0, 64'd0);
      run_instr($urandom, 2, 1, 1'b1, 64'd3);
      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit in the single-cycle LEGv8 datapath. It holds the PC and issues word reads to instruction memory over a req/ack handshake. It presents the fetched instruction, its 11-bit opcode field and its PC to the decode stage. It then computes the next PC from the control unit's pc_src decision and the sign-extended branch offset.

Parameters:
ADDR_W, 64, PC and memory address width in bits
PC_RESET, 0, PC value loaded on reset; must be a multiple of 4
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction read request
imem_addr  output  ADDR_W  byte address of requested word; equals pc
imem_ack  input  1  read data valid this cycle; sampled only while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  latched instruction
opcode  output  11  instr[31:21], to control unit opcode input
instr_pc  output  ADDR_W  PC of latched instruction
instr_valid  output  1  instr/opcode/instr_pc valid for decode/execute
pc_src  input  1  from control unit; 1 = take branch target
branch_offset  input  ADDR_W  sign-extended word offset from sign-extend unit
stall  input  1  hold current instruction; no retire
retired  output  CNT_W  count of retired instructions

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- On rst:
  - pc=PC_RESET, state=FETCH.
  - instr=0, instr_pc=0, instr_valid=0, retired=0.
  - imem_req is 1 immediately after reset release, because state is FETCH.
- State machine has two states, FETCH and EXEC.
- Outputs imem_req, imem_addr and instr_valid are decoded from registers only:
  - imem_req=1 iff state=FETCH.
  - instr_valid=1 iff state=EXEC.
  - imem_addr=pc.
- FETCH:
  - Wait for imem_ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, state<=EXEC.
  - Any number of wait cycles is allowed; pc and imem_addr stay stable while waiting.
  - stall and pc_src are ignored in FETCH.
- EXEC:
  - If stall=1: hold everything, including retired. pc_src and branch_offset are ignored.
  - If stall=0:
    - pc <= pc_src ? instr_pc + (branch_offset<<2) : instr_pc + 4.
    - retired <= retired+1.
    - state <= FETCH.
- imem_ack while in EXEC is ignored and does not change instr.
- opcode is combinational instr[31:21]; it is 0 after reset.
- Arithmetic:
  - All PC arithmetic is unsigned modulo 2^ADDR_W; wrap-around is silent.
  - branch_offset is two's complement, so negative offsets go backward.
  - Bits shifted out by <<2 are discarded.
  - pc[1:0] remains 00 for all time.
- retired wraps from all-ones to 0 without a flag.
- Minimum throughput is 2 cycles per instruction (ack in first FETCH cycle, no stall).
- Simultaneous events:
  - stall=1 with pc_src=1 in EXEC: stall wins; the branch is evaluated on the first non-stalled EXEC cycle, using pc_src/branch_offset values at that edge.
  - rst asserted during FETCH or EXEC: immediate return to reset state; any in-flight ack is discarded.
  - An ack in the first post-reset FETCH cycle is accepted as the response for PC_RESET.
- No X may appear on any output after reset, regardless of pc_src/branch_offset being X while not sampled.

Test Plan:
1. Reset with PC_RESET=0: imem_req=1, imem_addr=0, instr_valid=0, retired=0.
   - Release reset, ack=1 on first cycle with rdata=0x8B020020 → next cycle instr_valid=1, opcode=11'b10001011000, instr_pc=0.
2. Sequential fetch with immediate ack and stall=0, pc_src=0 for 4 instructions → imem_addr sequence 0,4,8,12,16; retired=4; one instruction every 2 cycles.
3. Delayed ack (ack after 3 wait cycles) → imem_req held 4 cycles, imem_addr constant at 8, instr latched only on ack cycle.
4. Branch: instr_pc=0x40, pc_src=1, branch_offset=-2 (all ones…10) → next imem_addr=0x38.
   - Then instr_pc=0x38, pc_src=1, offset=+5 → next imem_addr=0x4C.
5. Stall: in EXEC hold stall=1 for 3 cycles while pc_src toggles 1/0/1, then release with pc_src=0 → instr and instr_pc unchanged during stall; retired +1 only at release; next addr=instr_pc+4.
6. Wrap and reset:
   - instr_pc=0xFFFF_FFFF_FFFF_FFFC, pc_src=0 → next addr=0.
   - rst asserted mid-EXEC → instr_valid=0, pc=PC_RESET, retired=0 asynchronously, before the next edge.
